alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Integer execute unit of the criscv core for RV32I OP (0110011) and OP-IMM (0010011).
//  Core raises req with a decoded instruction, waits for comp, then writes rd to the register file.
//  Uses a req/comp handshake so that multi-cycle (serial shift) builds are transparent to the core.
// PARAMETERS
//  none
// PORTS
//  clk     in   1   core clock; all state updates on posedge
//  reset   in   1   asynchronous, active-low reset
//  req     in   1   operation request; held high by the core until it samples comp=1
//  funct3  in   3   instruction[14:12], selects the operation
//  modbit  in   1   instruction[30]: SUB/SRA select
//  imm     in   32  sign-extended I-immediate (instruction[31:20])
//  opcode  in   7   instruction[6:0]
//  rs1     in   32  operand A
//  rs2     in   32  operand B for OP
//  rd      out  32  result, registered
//  comp    out  1   result valid, registered
// BEHAVIOUR
//  Reset (reset=0, asynchronous): rd=0, comp=0, FSM=IDLE.
//  Operand B = opcode[5] ? rs2 : imm.  shamt = B[4:0].  All arithmetic is mod 2^32.
//  funct3 000: ADD. SUB only when opcode=0110011 and modbit=1. ADDI ignores modbit.
//         001: SLL.  010: SLT (signed, result 0/1).  011: SLTU (unsigned, result 0/1).
//         100: XOR.  101: SRL when modbit=0, SRA when modbit=1.  110: OR.  111: AND.
//  Any opcode other than 0010011 or 0110011: rd=0, comp still completes (no hang).
//  FSM:
//   IDLE: req=1 -> latch funct3/modbit/opcode/rs1/B. Single-cycle ops go to DONE; shifts
//         under the optional feature go to BUSY.
//   BUSY: one shift step per cycle. When the step count reaches 0, go to DONE.
//   DONE: rd holds the result and comp=1. Stay in DONE while req=1. On req=0, clear comp
//         and go to IDLE. comp must never be high in a cycle where req was low on the
//         previous edge.
//  Latency: req first sampled high at edge N -> comp=1 and rd valid after edge N+1.
//   In the single-cycle build, comp is visible in the cycle after N.
//  rd is stable from the assertion of comp until the next request starts.
//  rd keeps its last value in IDLE.
//  Core contract: comp is 0 when req rises, because a new req only comes at least one
//   cycle after the previous req fell.
//  Deasserting req in BUSY aborts the operation: go to IDLE, comp stays 0, rd unchanged.
//  Reset mid-operation: immediately return to IDLE with comp=0 and rd=0.
//  Input changes after the request is latched have no effect until the next request.
// CONFIGURATION
//  ALU_SERIAL_SHIFT_EN defined:
//   SLL/SRL/SRA use a 1-bit-per-cycle shifter.
//   comp asserts shamt+1 cycles after req is sampled (shamt=0 -> same as single-cycle).
//  ALU_SERIAL_SHIFT_EN undefined:
//   barrel shifter; every operation completes in the single-cycle latency.
// TESTING
//  OP ADD, rs1=5, rs2=7, modbit=0 -> rd=12, comp=1 one cycle after req is sampled.
//  OP SUB, rs1=3, rs2=5, modbit=1 -> rd=0xFFFFFFFE. ADDI with modbit=1 (imm=-1, rs1=3) -> rd=2.
//  SLT vs SLTU with rs1=0xFFFFFFFF, rs2=1 -> SLT=1, SLTU=0. SLTIU imm=-1, rs1=0 -> rd=1.
//  SRAI rs1=0x80000000, imm=0x41F (modbit=1) -> 0xFFFFFFFF. SRLI same rs1, shamt 31 -> 1.
//   With ALU_SERIAL_SHIFT_EN, comp arrives 32 cycles after req is sampled.
//  Handshake: hold req 3 cycles after comp -> comp and rd stay stable.
//   Drop req -> comp=0 next edge. Back-to-back ADD then XOR (0xF0 ^ 0xFF) -> 0x0F.
//  Assert reset low during a serial shift -> comp=0 and rd=0 at once.
//   After reset is released, a fresh ADD 1+1 -> rd=2.

Source files
------------

// File: rtl/alu.sv
// Integer execute unit for RV32I OP / OP-IMM with a req/comp handshake.
// Optional feature macro: ALU_SERIAL_SHIFT_EN selects a 1-bit-per-cycle shifter
// for SLL/SRL/SRA. When the macro is undefined, a barrel shifter is used and
// every operation completes with single-cycle latency.
module alu (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [2:0]  funct3,
   input  logic        modbit,
   input  logic [31:0] imm,
   input  logic [6:0]  opcode,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic [31:0] rd,
   output logic        comp
);

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [2:0]  funct3_r;
   logic        modbit_r;
   logic [6:0]  opcode_r;
   logic [31:0] a_r;
   logic [31:0] b_r;
   logic [31:0] rd_r;
   logic        comp_r;
   logic [31:0] b_s;
   logic [31:0] result_s;
   logic        serial_start_s;
   logic        last_step_s;

   // Combinational result of one operation; unknown opcodes produce zero.
   function automatic logic [31:0] alu_calc(
      input logic [2:0]  f3,
      input logic        mb,
      input logic [6:0]  opc,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic [31:0] r;
      logic [4:0]  sh;
      sh = b[4:0];
      r  = 32'd0;
      if ((opc == OPC_OP) || (opc == OPC_OPIMM)) begin
         case (f3)
            3'b000:  r = ((opc == OPC_OP) && mb) ? (a - b) : (a + b);
            3'b001:  r = a << sh;
            3'b010:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b011:  r = (a < b) ? 32'd1 : 32'd0;
            3'b100:  r = a ^ b;
            3'b101:  r = mb ? $unsigned($signed(a) >>> sh) : (a >> sh);
            3'b110:  r = a | b;
            3'b111:  r = a & b;
            default: r = 32'd0;
         endcase
      end else begin
         r = 32'd0;
      end
      return r;
   endfunction

   // OP takes rs2 as operand B, OP-IMM takes the immediate.
   assign b_s = opcode[5] ? rs2 : imm;

`ifdef ALU_SERIAL_SHIFT_EN
   logic [31:0] sh_r;
   logic [4:0]  cnt_r;
   logic        valid_opc_s;
   logic        in_shift_s;
   logic        lat_shift_s;

   assign valid_opc_s    = (opcode == OPC_OP) || (opcode == OPC_OPIMM);
   assign in_shift_s     = valid_opc_s && ((funct3 == 3'b001) || (funct3 == 3'b101));
   assign serial_start_s = in_shift_s && (b_s[4:0] != 5'd0);
   assign last_step_s    = (cnt_r == 5'd1);
   assign lat_shift_s    = ((opcode_r == OPC_OP) || (opcode_r == OPC_OPIMM)) &&
                           ((funct3_r == 3'b001) || (funct3_r == 3'b101));
   assign result_s       = lat_shift_s ? sh_r : alu_calc(funct3_r, modbit_r, opcode_r, a_r, b_r);

   // Serial shifter: load on request, then move one bit per BUSY cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_r  <= 32'd0;
         cnt_r <= 5'd0;
      end else if ((state_r == IDLE) && req) begin
         sh_r  <= rs1;
         cnt_r <= b_s[4:0];
      end else if (state_r == BUSY) begin
         cnt_r <= cnt_r - 5'd1;
         if (funct3_r == 3'b001) begin
            sh_r <= {sh_r[30:0], 1'b0};
         end else begin
            sh_r <= {(modbit_r & sh_r[31]), sh_r[31:1]};
         end
      end else begin
         sh_r  <= sh_r;
         cnt_r <= cnt_r;
      end
   end
`else
   assign serial_start_s = 1'b0;
   assign last_step_s    = 1'b1;
   assign result_s       = alu_calc(funct3_r, modbit_r, opcode_r, a_r, b_r);
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; dropping req in any state returns to IDLE.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (req) begin
               state_next_s = serial_start_s ? BUSY : DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (!req) begin
               state_next_s = IDLE;
            end else if (last_step_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = BUSY;
            end
         end
         DONE: begin
            if (req) begin
               state_next_s = DONE;
            end else begin
               state_next_s = IDLE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Operand capture on request, result/comp update in DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         funct3_r <= 3'd0;
         modbit_r <= 1'b0;
         opcode_r <= 7'd0;
         a_r      <= 32'd0;
         b_r      <= 32'd0;
         rd_r     <= 32'd0;
         comp_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               comp_r <= 1'b0;
               if (req) begin
                  funct3_r <= funct3;
                  modbit_r <= modbit;
                  opcode_r <= opcode;
                  a_r      <= rs1;
                  b_r      <= b_s;
               end
            end
            DONE: begin
               if (req) begin
                  rd_r   <= result_s;
                  comp_r <= 1'b1;
               end else begin
                  comp_r <= 1'b0;
               end
            end
            default: comp_r <= 1'b0;
         endcase
      end
   end

   assign rd   = rd_r;
   assign comp = comp_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu with an expected-result queue.
module tb_alu;

   localparam logic [6:0] OP    = 7'b0110011;
   localparam logic [6:0] OPIMM = 7'b0010011;

   logic        clk;
   logic        reset;
   logic        req;
   logic [2:0]  funct3;
   logic        modbit;
   logic [31:0] imm;
   logic [6:0]  opcode;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] rd;
   logic        comp;

   int          n_vec;
   int          n_err;
   logic [31:0] exp_q[$];
   logic [31:0] prev_rd;

   alu dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .funct3 (funct3),
      .modbit (modbit),
      .imm    (imm),
      .opcode (opcode),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd),
      .comp   (comp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edges from request drive until comp is first seen (sampled 1 time unit after each edge).
   function automatic int exp_lat(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] b);
      int l;
      l = 2;
`ifdef ALU_SERIAL_SHIFT_EN
      if (((opc == OP) || (opc == OPIMM)) && ((f3 == 3'b001) || (f3 == 3'b101)) && (b[4:0] != 5'd0))
         l = 2 + int'(b[4:0]);
`endif
      return l;
   endfunction

   task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                         input logic mb, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_rd, input int hold);
      int          cyc;
      logic [31:0] want;
      @(negedge clk);
      opcode = opc; funct3 = f3; modbit = mb; rs1 = a; rs2 = b; imm = b; req = 1'b1;
      exp_q.push_back(exp_rd);
      cyc = 0;
      while ((comp !== 1'b1) && (cyc < 64)) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            opcode = 7'($urandom); funct3 = 3'($urandom); modbit = 1'($urandom);
            rs1 = $urandom; rs2 = $urandom; imm = $urandom;
         end
      end
      check({tag, "_lat"}, 32'(cyc), 32'(exp_lat(opc, f3, b)));
      want = exp_q.pop_front();
      check({tag, "_rd"}, rd, want);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_comp"}, {31'd0, comp}, 32'd1);
         check({tag, "_hold_rd"}, rd, want);
      end
      @(negedge clk);
      req = 1'b0;
      @(posedge clk); #1;
      check({tag, "_drop_comp"}, {31'd0, comp}, 32'd0);
      check({tag, "_idle_rd"}, rd, want);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      reset = 1'b0; req = 1'b0; funct3 = 3'd0; modbit = 1'b0; imm = 32'd0;
      opcode = 7'd0; rs1 = 32'd0; rs2 = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd", rd, 32'd0);
      check("reset_comp", {31'd0, comp}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      run_op("add",   OP,    3'b000, 1'b0, 32'd5,          32'd7,          32'd12,         3);
      run_op("sub",   OP,    3'b000, 1'b1, 32'd3,          32'd5,          32'hFFFF_FFFE,  0);
      run_op("addi",  OPIMM, 3'b000, 1'b1, 32'd3,          32'hFFFF_FFFF,  32'd2,          0);
      run_op("slt",   OP,    3'b010, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd1,          0);
      run_op("sltu",  OP,    3'b011, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'd0,          0);
      run_op("sltiu", OPIMM, 3'b011, 1'b0, 32'd0,          32'hFFFF_FFFF,  32'd1,          0);
      run_op("srai",  OPIMM, 3'b101, 1'b1, 32'h8000_0000,  32'h0000_041F,  32'hFFFF_FFFF,  1);
      run_op("srli",  OPIMM, 3'b101, 1'b0, 32'h8000_0000,  32'h0000_001F,  32'd1,          0);
      run_op("sll",   OP,    3'b001, 1'b0, 32'd1,          32'h0000_0024,  32'h0000_0010,  0);
      run_op("sra",   OP,    3'b101, 1'b1, 32'hF000_0000,  32'd4,          32'hFF00_0000,  0);
      run_op("sll0",  OP,    3'b001, 1'b0, 32'h1234_5678,  32'd0,          32'h1234_5678,  0);
      run_op("or",    OP,    3'b110, 1'b0, 32'hA0A0_0000,  32'h0000_0505,  32'hA0A0_0505,  0);
      run_op("andi",  OPIMM, 3'b111, 1'b0, 32'hDEAD_BEEF,  32'h0000_0FF0,  32'h0000_0EE0,  0);
      run_op("badop", 7'b0110111, 3'b000, 1'b0, 32'd9,     32'd9,          32'd0,          0);
      run_op("b2b_add", OP,  3'b000, 1'b0, 32'd100,        32'd23,         32'd123,        0);
      run_op("b2b_xor", OP,  3'b100, 1'b0, 32'h0000_00F0,  32'h0000_00FF,  32'h0000_000F,  0);

      // Request withdrawn before completion: comp stays low, rd untouched.
      prev_rd = 32'h0000_000F;
      @(negedge clk);
      opcode = OP; funct3 = 3'b001; modbit = 1'b0; rs1 = 32'd3; rs2 = 32'd10; imm = 32'd10; req = 1'b1;
      @(posedge clk); #1;
      check("abort_comp0", {31'd0, comp}, 32'd0);
      @(negedge clk);
      req = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         check("abort_comp", {31'd0, comp}, 32'd0);
         check("abort_rd", rd, prev_rd);
      end

      // Reset asserted while a long shift is in flight.
      @(negedge clk);
      opcode = OPIMM; funct3 = 3'b101; modbit = 1'b1; rs1 = 32'h8000_0000; imm = 32'h0000_041F;
      rs2 = 32'd0; req = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_comp", {31'd0, comp}, 32'd0);
      check("midreset_rd", rd, 32'd0);
      req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      run_op("post_reset_add", OP, 3'b000, 1'b0, 32'd1, 32'd1, 32'd2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
